// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int IW_DEFAULT = 11;
  localparam int AW_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_CNT  = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WR   = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ZLEN = 2'd1;
  localparam logic [1:0] ERR_FMT  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  // States in which a stream byte may be consumed.
  function automatic logic accepting(input state_t s);
    return (s == S_CNT) || (s == S_LO) || (s == S_HI) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Loads a framed byte stream (count, low/high byte pairs, XOR checksum)
// into instruction memory and launches the core when the frame checks out.
//
// Handshake: a byte is consumed on the rising edge of clk when in_valid and
// in_ready are both high; in_ready is registered and never depends on
// in_valid, and in_data is ignored whenever no byte is consumed.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IW = IW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [IW-1:0] im_wdata,
  output logic          core_start,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output state_t        dbg_state
);

  // Number of instruction bits carried by the high byte of each pair.
  localparam int HB = IW - 8;

  state_t     state;
  state_t     next_state;
  logic       in_ready_q;
  logic       core_start_q;
  logic [7:0] remaining;
  logic [7:0] csum;
  logic       accept;
  logic       hi_bad;

  assign accept = in_valid && in_ready;
  assign hi_bad = |in_data[7:HB];

  // Next-state decode for the load sequence.
  always_comb begin
    next_state = state;
    case (state)
      S_CNT:   if (accept) next_state = (in_data == 8'd0) ? S_ERR : S_LO;
      S_LO:    if (accept) next_state = S_HI;
      S_HI:    if (accept) next_state = hi_bad ? S_ERR : S_WR;
      S_WR:    next_state = (remaining == 8'd1) ? S_CSUM : S_LO;
      S_CSUM:  if (accept) next_state = (in_data == csum) ? S_DONE : S_ERR;
      default: next_state = state;
    endcase
  end

  // State register plus word assembly, address/count stepping and checksum.
  always_ff @(posedge clk) begin
    if (start) begin
      state        <= S_CNT;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      remaining    <= '0;
      csum         <= '0;
      im_waddr     <= '0;
      im_wdata     <= '0;
      err_code     <= ERR_NONE;
    end else begin
      state        <= next_state;
      in_ready_q   <= accepting(next_state);
      core_start_q <= 1'b0;
      case (state)
        S_CNT: if (accept) begin
          if (in_data == 8'd0) begin
            err_code <= ERR_ZLEN;
          end else begin
            remaining <= in_data;
            csum      <= in_data;
          end
        end
        S_LO: if (accept) begin
          im_wdata[7:0] <= in_data;
          csum          <= csum ^ in_data;
        end
        S_HI: if (accept) begin
          if (hi_bad) begin
            err_code <= ERR_FMT;
          end else begin
            im_wdata[IW-1:8] <= in_data[HB-1:0];
            csum             <= csum ^ in_data;
          end
        end
        S_WR: begin
          im_waddr  <= im_waddr + 1'b1;
          remaining <= remaining - 8'd1;
        end
        S_CSUM: if (accept) begin
          if (in_data == csum) core_start_q <= 1'b1;
          else                 err_code     <= ERR_CSUM;
        end
        default: ;
      endcase
    end
  end

  // Output decode; start forces everything quiet in the cycle it is seen.
  always_comb begin
    in_ready   = in_ready_q && !start;
    im_we      = (state == S_WR) && !start;
    core_start = core_start_q && !start;
    done       = ((state == S_DONE) || (state == S_ERR)) && !start;
    err        = (state == S_ERR) && !start;
    dbg_state  = state;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of framed streams plus hand-written
// sequences for zero-length timing, trailing bytes and mid-load abort.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int IW = 11;
  localparam int AW = 10;
  localparam int EW = AW + IW;

  logic          clk = 1'b0;
  logic          start = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [IW-1:0] im_wdata;
  logic          core_start;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  state_t        dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  prog_loader #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .core_start(core_start), .done(done), .err(err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int start_pulses = 0;
  int wr_ready_viol = 0;

  always @(negedge clk) begin
    if (!start) begin
      if (im_we) got_q.push_back({im_waddr, im_wdata});
      if (core_start) start_pulses++;
      if (dbg_state == S_WR && in_ready) wr_ready_viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_waddr", {22'd0, im_waddr}, 32'd0);
    chk("rst_wdata", {21'd0, im_wdata}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_CNT});
    got_q.delete();
    exp_q.delete();
    start_pulses = 0;
    wr_ready_viol = 0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int budget;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data = b;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=none required=byte %0h accepted", b);
    end
  endtask

  task automatic send_stream(input logic [63:0] bytes, input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) send_byte(bytes[8*i +: 8], gaps);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_write"}, {11'd0, got_q[i]}, {11'd0, exp_q[i]});
    chk({tag, "_wr_ready"}, wr_ready_viol, 32'd0);
  endtask

  task automatic check_end(input string tag, input logic e, input logic [1:0] code, input int starts);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
    chk({tag, "_core_start"}, start_pulses, starts);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Stream bytes are packed little-end first: byte i at bits [8i+7:8i].
  typedef struct packed {
    logic [63:0]   bytes;
    int            nb;
    bit            gaps;
    int            nw;
    logic [EW-1:0] w0;
    logic [EW-1:0] w1;
    logic          e;
    logic [1:0]    code;
    int            starts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // nominal, held valid
    vecs[0] = '{64'h7A_04_7F_02_01_02, 6, 1'b0, 2, {10'd0, 11'h201}, {10'd1, 11'h47F}, 1'b0, ERR_NONE, 1};
    // checksum error
    vecs[1] = '{64'h7B_04_7F_02_01_02, 6, 1'b0, 2, {10'd0, 11'h201}, {10'd1, 11'h47F}, 1'b1, ERR_CSUM, 0};
    // format error on first high byte
    vecs[2] = '{64'h09_05_01, 3, 1'b0, 0, '0, '0, 1'b1, ERR_FMT, 0};
    // nominal with random gaps in in_valid
    vecs[3] = '{64'h7A_04_7F_02_01_02, 6, 1'b1, 2, {10'd0, 11'h201}, {10'd1, 11'h47F}, 1'b0, ERR_NONE, 1};
    // single word, all 11 bits set: 01^FF^07 = F9
    vecs[4] = '{64'hF9_07_FF_01, 4, 1'b0, 1, {10'd0, 11'h7FF}, '0, 1'b0, ERR_NONE, 1};
    // second high byte has bit 3 set: one write, then format error
    vecs[5] = '{64'h08_7F_02_01_02, 5, 1'b0, 1, {10'd0, 11'h201}, '0, 1'b1, ERR_FMT, 0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vecs[v].nw > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) exp_q.push_back(vecs[v].w1);
      send_stream(vecs[v].bytes, vecs[v].nb, vecs[v].gaps);
      repeat (4) @(negedge clk);
      check_writes($sformatf("vec%0d", v));
      check_end($sformatf("vec%0d", v), vecs[v].e, vecs[v].code, vecs[v].starts);
    end

    // zero length: error visible in the cycle after acceptance
    do_reset();
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    chk("zlen_done_next", {31'd0, done}, 32'd1);
    chk("zlen_err_code", {30'd0, err_code}, {30'd0, ERR_ZLEN});
    repeat (3) @(negedge clk);
    check_writes("zlen");
    check_end("zlen", 1'b1, ERR_ZLEN, 0);

    // trailing bytes after a good load are not consumed
    do_reset();
    exp_q.push_back({10'd0, 11'h201});
    exp_q.push_back({10'd1, 11'h47F});
    send_stream(64'h7A_04_7F_02_01_02, 6, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("trail_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check_writes("trail");
    check_end("trail", 1'b0, ERR_NONE, 1);
    chk("trail_wdata_hold", {21'd0, im_wdata}, 32'h47F);

    // start mid-load aborts, then a fresh load starts at address 0
    do_reset();
    send_stream(64'h02_01_02, 3, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_state", {29'd0, dbg_state}, {29'd0, S_CNT});
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_wdata", {21'd0, im_wdata}, 32'd0);
    chk("abort_waddr", {22'd0, im_waddr}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    do_reset();
    exp_q.push_back({10'd0, 11'h201});
    exp_q.push_back({10'd1, 11'h47F});
    send_stream(64'h7A_04_7F_02_01_02, 6, 1'b0);
    repeat (4) @(negedge clk);
    check_writes("reload");
    check_end("reload", 1'b0, ERR_NONE, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: the core fetches 11-bit instructions from instruction memory, and this block loads them.
- Accepts a framed byte stream over a valid/ready handshake and packs byte pairs into instruction words.
- Writes the words sequentially into instruction memory, then verifies an XOR checksum.
- On success it pulses core_start to launch the core at address 0.

Parameters:
- IW, 11, instruction word width.
- AW, 10, instruction-memory write address width.

Ports:
- clk  input  1  system clock.
- start  input  1  synchronous active-high reset; clears the block and arms it for a new load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  block can accept a byte this cycle.
- im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- im_waddr  output  AW  instruction-memory write address.
- im_wdata  output  IW  instruction word to write.
- core_start  output  1  one-cycle pulse on successful load.
- done  output  1  load finished (success or error); sticky until start.
- err  output  1  load failed; sticky until start.
- err_code  output  2  0 none, 1 zero length, 2 format, 3 checksum.

Behaviour:
- Interface: one clock, clk. Reset is start, synchronous and active-high.
- Reset values while start=1, and in the cycle it is sampled:
  - state=S_CNT, in_ready=0, im_we=0, im_waddr=0, im_wdata=0, core_start=0, done=0, err=0, err_code=0.
  - Remaining count=0, checksum accumulator=0.
- start asserted in any state, mid-load included, aborts immediately. Memory contents already written are left as-is.
- Frame format: byte0=N (instruction count), then 2N bytes as low/high pairs, then one checksum byte.
  - Checksum = XOR of byte0 and all 2N data bytes.
- A byte is accepted on posedge when in_valid && in_ready. in_ready is a registered/state-decoded output, high only in S_CNT, S_LO, S_HI and S_CSUM.
- FSM:
  - S_CNT, accept:
    - N=0: go to S_ERR, err_code=1.
    - Otherwise latch remaining=N, csum=byte, go to S_LO.
  - S_LO, accept: latch im_wdata[7:0]=byte, csum^=byte, go to S_HI.
  - S_HI, accept:
    - If byte[7:3]!=0: go to S_ERR, err_code=2. No write occurs.
    - Else latch im_wdata[10:8]=byte[2:0], csum^=byte, go to S_WR.
  - S_WR: im_we=1 for exactly this cycle with the current im_waddr and im_wdata.
    - Next cycle: im_waddr+=1, remaining-=1.
    - Go to S_CSUM if remaining was 1, else S_LO.
  - S_CSUM, accept:
    - byte==csum: go to S_DONE.
    - Else go to S_ERR, err_code=3.
  - S_DONE: done=1. core_start=1 only in the first cycle of S_DONE. Stay until start.
  - S_ERR: done=1, err=1, core_start never asserts. Stay until start.
- Throughput: 3 cycles per instruction minimum (LO, HI, WR).
- Write latency: im_we asserts 1 cycle after the high byte is accepted.
- in_valid while in_ready=0 (S_WR, S_DONE, S_ERR): the byte is not consumed. Trailing bytes after the checksum are ignored.
- Address wrap: im_waddr wraps modulo 2^AW; this only matters when AW<8. N max 255.
- im_wdata holds its last value when im_we=0.
- The checksum is compared only after all N words are written.

Decomposition:
- Shared package loader_pkg:
  - typedef enum for states {S_CNT,S_LO,S_HI,S_WR,S_CSUM,S_DONE,S_ERR}.
  - localparams for err codes (ERR_NONE=0, ERR_ZLEN=1, ERR_FMT=2, ERR_CSUM=3).
  - IW default.
- No sub-module: FSM, counter and checksum stay in one always_ff plus small output decode.

Test Plan:
- Nominal load: stream 02,01,02,7F,04,7A with in_valid held high.
  - im_we pulses twice: (addr0, 0x201) then (addr1, 0x47F).
  - Then done=1, err=0, and core_start high for exactly 1 cycle.
- Checksum error: same stream with last byte 7B.
  - Both writes occur, then done=1, err=1, err_code=3, no core_start.
- Format error: stream 01,05,09.
  - No im_we, err=1, err_code=2, in_ready=0 afterwards.
- Zero length: stream 00.
  - err_code=1, done=1 in the cycle after acceptance, no writes.
- Backpressure and gaps: nominal stream with in_valid toggling 1/0 randomly.
  - Identical writes and result to the nominal load.
  - in_ready=0 in each S_WR cycle, and no byte is lost or duplicated.
- Reset mid-load: assert start after the third byte of the nominal stream.
  - All outputs return to reset values the next cycle.
  - A fresh full nominal stream then loads correctly from addr 0.
